// File: rtl/ahb_bram_ctrl_pkg.sv
// Shared AHB-Lite encodings for the block-RAM controller and its helpers.
package ahb_bram_ctrl_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  localparam logic       HRESP_OKAY = 1'b0;
  localparam logic [3:0] MASK_ALL   = 4'b1111;

endpackage

// File: rtl/ahb_bram_ctrl_mask.sv
// Byte-lane enable decode from transfer size and the low address bits.
module ahb_byte_mask
  import ahb_bram_ctrl_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] haddr_lo,
  output logic [3:0] mask
);

  // Misaligned low bits are dropped for half and word; oversize counts as word.
  always_comb begin
    mask = MASK_ALL;
    case (hsize)
      HSIZE_BYTE: mask = 4'b0001 << haddr_lo;
      HSIZE_HALF: mask = 4'b0011 << {haddr_lo[1], 1'b0};
      HSIZE_WORD: mask = MASK_ALL;
      default:    mask = MASK_ALL;
    endcase
  end

endmodule

// File: rtl/ahb_bram_ctrl.sv
// Zero-wait-state AHB-Lite slave driving a dual-port block RAM, with
// forwarding of just-written bytes to a same-word read in the next cycle.
module ahb_bram_ctrl
  import ahb_bram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic [31:0]           HRDATA,
  output logic                  HRESP,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [31:0]           dina,
  output logic [3:0]            wea,
  output logic [ADDR_WIDTH-1:0] addrb,
  input  logic [31:0]           doutb
);

  logic                  trans_ok;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  raw_hit;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [3:0]            byte_mask;
  logic                  unused_haddr;

  logic                  pend;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic [3:0]            pend_mask;

  logic                  fwd_valid;
  logic [3:0]            fwd_mask;
  logic [31:0]           fwd_data;

  assign trans_ok = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  assign wr_ok    = trans_ok & HWRITE;
  assign rd_ok    = trans_ok & ~HWRITE;

  // Upper address bits are ignored, so accesses wrap modulo the RAM size.
  assign word_idx     = HADDR[ADDR_WIDTH+1:2];
  assign unused_haddr = ^HADDR[31:ADDR_WIDTH+2];

  ahb_byte_mask u_mask (
    .hsize    (HSIZE),
    .haddr_lo (HADDR[1:0]),
    .mask     (byte_mask)
  );

  // Write address phase is held here until its data arrives next cycle.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      pend      <= 1'b0;
      pend_addr <= '0;
      pend_mask <= 4'b0000;
    end else begin
      pend <= wr_ok;
      if (wr_ok) begin
        pend_addr <= word_idx;
        pend_mask <= byte_mask;
      end
    end
  end

  // The RAM reads the old word on the same edge the write commits, so the
  // written lanes are captured here and substituted in the read data phase.
  assign raw_hit = rd_ok & pend & (word_idx == pend_addr);

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      fwd_valid <= 1'b0;
      fwd_mask  <= 4'b0000;
      fwd_data  <= 32'h0;
    end else begin
      fwd_valid <= raw_hit;
      if (raw_hit) begin
        fwd_mask <= pend_mask;
        fwd_data <= HWDATA;
      end
    end
  end

  assign addra     = pend_addr;
  assign wea       = pend ? pend_mask : 4'b0000;
  assign dina      = HWDATA;
  assign addrb     = word_idx;
  assign HREADYOUT = 1'b1;
  assign HRESP     = HRESP_OKAY;

  always_comb begin
    HRDATA = doutb;
    for (int i = 0; i < 4; i++) begin
      if (fwd_valid && fwd_mask[i]) HRDATA[8*i +: 8] = fwd_data[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Self-checking bench for ahb_bram_ctrl with a behavioural dual-port RAM.
module tb_ahb_bram_ctrl;
  import ahb_bram_ctrl_pkg::*;

  localparam int AW    = 12;
  localparam int WORDS = 1 << AW;

  logic          clka = 1'b0;
  logic          rsta = 1'b1;
  logic          HSEL = 1'b0;
  logic [31:0]   HADDR = 32'h0;
  logic [1:0]    HTRANS = HTRANS_IDLE;
  logic [2:0]    HSIZE = HSIZE_WORD;
  logic          HWRITE = 1'b0;
  logic [31:0]   HWDATA = 32'h0;
  logic          HREADY = 1'b1;
  logic          HREADYOUT;
  logic [31:0]   HRDATA;
  logic          HRESP;
  logic [AW-1:0] addra;
  logic [31:0]   dina;
  logic [3:0]    wea;
  logic [AW-1:0] addrb;
  logic [31:0]   doutb;

  logic [31:0] ram     [0:WORDS-1];
  logic [31:0] ref_mem [0:WORDS-1];
  logic [31:0] sb [$];
  logic [31:0] data_next = 32'h0;
  int checks = 0;
  int passed = 0;

  ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clka(clka), .rsta(rsta), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP), .addra(addra),
    .dina(dina), .wea(wea), .addrb(addrb), .doutb(doutb)
  );

  always #5 clka = ~clka;

  // Block RAM: registered read, byte-enabled write, read-before-write.
  always @(posedge clka) begin
    doutb <= ram[addrb];
    for (int i = 0; i < 4; i++)
      if (wea[i]) ram[addra][8*i +: 8] <= dina[8*i +: 8];
  end

  function automatic logic [31:0] preload(int i);
    return 32'hA5000000 ^ (i * 32'h00010203);
  endfunction

  function automatic logic [3:0] model_mask(logic [2:0] size, logic [1:0] lo);
    if (size == 3'd0) return 4'b0001 << lo;
    if (size == 3'd1) return lo[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  // One bus cycle: address phase of this transfer plus data of the previous write.
  task automatic step(input logic sel, input logic [1:0] trans, input logic [2:0] size,
                      input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic rdy);
    logic [AW-1:0] idx;
    logic [3:0]    m;
    @(posedge clka);
    #1;
    HWDATA    = data_next;
    data_next = $urandom;
    HSEL = sel; HTRANS = trans; HSIZE = size; HWRITE = wr; HADDR = addr; HREADY = rdy;
    idx = addr[AW+1:2];
    if (sel && trans[1] && rdy) begin
      if (wr) begin
        m = model_mask(size, addr[1:0]);
        for (int i = 0; i < 4; i++)
          if (m[i]) ref_mem[idx][8*i +: 8] = wdata[8*i +: 8];
        data_next = wdata;
      end else begin
        sb.push_back(ref_mem[idx]);
      end
    end
    @(negedge clka);
  endtask

  task automatic idle();
    step(1'b0, HTRANS_IDLE, HSIZE_WORD, 1'b0, 32'h0, 32'h0, 1'b1);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clka);
    @(negedge clka);
    checks++; if (wea !== 4'b0000) $display("[TB] FAIL reset_wea: got %b want 0000", wea); else passed++;
    checks++; if (HREADYOUT !== 1'b1) $display("[TB] FAIL reset_hreadyout: got %b want 1", HREADYOUT); else passed++;
    checks++; if (HRESP !== 1'b0) $display("[TB] FAIL reset_hresp: got %b want 0", HRESP); else passed++;
    checks++; if (addra !== '0) $display("[TB] FAIL reset_addra: got %h want 0", addra); else passed++;
    checks++; if (HRDATA !== ref_mem[0]) $display("[TB] FAIL reset_hrdata: got %h want %h", HRDATA, ref_mem[0]); else passed++;
    @(posedge clka);
    #1 rsta = 1'b0;
  endtask

  task automatic test_word_write();
    logic [31:0] exp;
    step(1'b1, HTRANS_NONSEQ, HSIZE_WORD, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
    idle();
    checks++; if (wea !== 4'b1111) $display("[TB] FAIL word_wea: got %b want 1111", wea); else passed++;
    checks++; if (addra !== 12'd4) $display("[TB] FAIL word_addra: got %h want 4", addra); else passed++;
    checks++; if (dina !== 32'hDEADBEEF) $display("[TB] FAIL word_dina: got %h want deadbeef", dina); else passed++;
    step(1'b1, HTRANS_NONSEQ, HSIZE_WORD, 1'b0, 32'h10, 32'h0, 1'b1);
    checks++; if (wea !== 4'b0000) $display("[TB] FAIL word_wea_clear: got %b want 0000", wea); else passed++;
    step(1'b1, HTRANS_NONSEQ, HSIZE_WORD, 1'b0, 32'h0000_4010, 32'h0, 1'b1);
    checks++;
    if (sb.size() == 0) $display("[TB] FAIL word_read: scoreboard empty");
    else begin
      exp = sb.pop_front();
      if (HRDATA !== exp) $display("[TB] FAIL word_read: got %h want %h", HRDATA, exp); else passed++;
    end
    idle();
    checks++;
    if (sb.size() == 0) $display("[TB] FAIL word_wrap_read: scoreboard empty");
    else begin
      exp = sb.pop_front();
      if (HRDATA !== exp) $display("[TB] FAIL word_wrap_read: got %h want %h", HRDATA, exp); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    logic [3:0]  want;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, HTRANS_NONSEQ, HSIZE_BYTE, 1'b1, 32'h20 + i, (32'h11 * (i + 1)) << (8 * i), 1'b1);
      if (i > 0) begin
        want = 4'b0001 << (i - 1);
        checks++; if (wea !== want || addra !== 12'd8)
          $display("[TB] FAIL b2b_wea%0d: got %b@%h want %b@008", i - 1, wea, addra, want); else passed++;
      end
    end
    idle();
    checks++; if (wea !== 4'b1000 || addra !== 12'd8)
      $display("[TB] FAIL b2b_wea3: got %b@%h want 1000@008", wea, addra); else passed++;
    checks++; if (dina[31:24] !== 8'h44) $display("[TB] FAIL b2b_dina3: got %h want 44", dina[31:24]); else passed++;
    step(1'b1, HTRANS_NONSEQ, HSIZE_WORD, 1'b0, 32'h20, 32'h0, 1'b1);
    idle();
    checks++;
    if (sb.size() == 0) $display("[TB] FAIL b2b_read: scoreboard empty");
    else begin
      exp = sb.pop_front();
      if (HRDATA !== exp) $display("[TB] FAIL b2b_read: got %h want %h", HRDATA, exp); else passed++;
    end
  endtask

  task automatic test_forwarding();
    logic [31:0] exp;
    step(1'b1, HTRANS_NONSEQ, HSIZE_WORD, 1'b1, 32'h30, 32'h12345678, 1'b1);
    idle();
    step(1'b1, HTRANS_NONSEQ, HSIZE_HALF, 1'b1, 32'h32, 32'hABCD0000, 1'b1);
    step(1'b1, HTRANS_NONSEQ, HSIZE_WORD, 1'b0, 32'h30, 32'h0, 1'b1);
    checks++; if (wea !== 4'b1100) $display("[TB] FAIL fwd_wea: got %b want 1100", wea); else passed++;
    idle();
    checks++;
    if (sb.size() == 0) $display("[TB] FAIL fwd_read: scoreboard empty");
    else begin
      exp = sb.pop_front();
      if (HRDATA !== exp) $display("[TB] FAIL fwd_read: got %h want %h", HRDATA, exp); else passed++;
    end
  endtask

  task automatic test_no_forward();
    logic [31:0] exp;
    step(1'b1, HTRANS_NONSEQ, HSIZE_WORD, 1'b1, 32'h40, 32'h0BADF00D, 1'b1);
    step(1'b1, HTRANS_NONSEQ, HSIZE_WORD, 1'b0, 32'h44, 32'h0, 1'b1);
    idle();
    checks++;
    if (sb.size() == 0) $display("[TB] FAIL nofwd_read: scoreboard empty");
    else begin
      exp = sb.pop_front();
      if (HRDATA !== exp) $display("[TB] FAIL nofwd_read: got %h want %h", HRDATA, exp); else passed++;
    end
  endtask

  task automatic test_ignored();
    logic [31:0] exp;
    step(1'b1, HTRANS_IDLE, HSIZE_WORD, 1'b1, 32'h50, 32'h11111111, 1'b1);
    step(1'b0, HTRANS_NONSEQ, HSIZE_WORD, 1'b1, 32'h50, 32'h22222222, 1'b1);
    checks++; if (wea !== 4'b0000) $display("[TB] FAIL ign_idle_wea: got %b want 0000", wea); else passed++;
    step(1'b1, HTRANS_NONSEQ, HSIZE_WORD, 1'b1, 32'h50, 32'h33333333, 1'b0);
    checks++; if (wea !== 4'b0000) $display("[TB] FAIL ign_hsel_wea: got %b want 0000", wea); else passed++;
    step(1'b1, HTRANS_BUSY, HSIZE_WORD, 1'b1, 32'h50, 32'h44444444, 1'b1);
    checks++; if (wea !== 4'b0000) $display("[TB] FAIL ign_hready_wea: got %b want 0000", wea); else passed++;
    checks++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0)
      $display("[TB] FAIL ign_resp: got ready=%b resp=%b want 1/0", HREADYOUT, HRESP); else passed++;
    step(1'b1, HTRANS_NONSEQ, HSIZE_WORD, 1'b0, 32'h50, 32'h0, 1'b1);
    checks++; if (wea !== 4'b0000) $display("[TB] FAIL ign_busy_wea: got %b want 0000", wea); else passed++;
    idle();
    checks++;
    if (sb.size() == 0) $display("[TB] FAIL ign_read: scoreboard empty");
    else begin
      exp = sb.pop_front();
      if (HRDATA !== exp) $display("[TB] FAIL ign_read: got %h want %h", HRDATA, exp); else passed++;
    end
  endtask

  task automatic test_reset_midwrite();
    logic [31:0] exp;
    logic [31:0] saved;
    saved = ref_mem[24];
    step(1'b1, HTRANS_NONSEQ, HSIZE_WORD, 1'b1, 32'h60, 32'hCAFEF00D, 1'b1);
    ref_mem[24] = saved;
    @(posedge clka);
    #1;
    HWDATA = data_next;
    HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0;
    #1 rsta = 1'b1;
    #1;
    checks++; if (wea !== 4'b0000) $display("[TB] FAIL rst_mid_wea: got %b want 0000", wea); else passed++;
    rsta = 1'b0;
    @(negedge clka);
    checks++; if (wea !== 4'b0000) $display("[TB] FAIL rst_mid_wea_after: got %b want 0000", wea); else passed++;
    step(1'b1, HTRANS_NONSEQ, HSIZE_WORD, 1'b0, 32'h60, 32'h0, 1'b1);
    checks++; if (wea !== 4'b0000) $display("[TB] FAIL rst_mid_wea_late: got %b want 0000", wea); else passed++;
    idle();
    checks++;
    if (sb.size() == 0) $display("[TB] FAIL rst_mid_read: scoreboard empty");
    else begin
      exp = sb.pop_front();
      if (HRDATA !== exp) $display("[TB] FAIL rst_mid_read: got %h want %h", HRDATA, exp); else passed++;
    end
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      ram[i]     = preload(i);
      ref_mem[i] = preload(i);
    end
    $display("[TB] starting ahb_bram_ctrl bench");
    test_reset();
    test_word_write();
    test_back_to_back();
    test_forwarding();
    test_no_forward();
    test_ignored();
    test_reset_midwrite();
    checks++; if (sb.size() != 0) $display("[TB] FAIL sb_drain: got %0d entries want 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
